// File: rtl/ensemble_vote_combiner.sv
// ensemble_vote_combiner
// Aligns three classifier prediction streams through per-channel FIFOs and
// emits one majority-voted class label per sample on an AXI-Stream master.
// Optional build macro ENSEMBLE_AGREE_CNT_EN adds the agreement count
// (1..3) in m_axis_tdata[17:16].
//
// Handshake: a beat transfers on a rising edge where tvalid && tready are
// both high; a master holds tdata/tlast stable while tvalid is high and
// tready is low, and tvalid never drops before the beat transfers.
module ensemble_vote_combiner #(
  parameter int DATA_WIDTH  = 32,
  parameter int KEEP_WIDTH  = 4,
  parameter int CLASS_WIDTH = 8,
  parameter int FIFO_DEPTH  = 4,
  parameter int TIE_SEL     = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata_0,
  input  logic [KEEP_WIDTH-1:0] s_axis_tkeep_0,
  input  logic                  s_axis_tvalid_0,
  output logic                  s_axis_tready_0,
  input  logic                  s_axis_tlast_0,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata_1,
  input  logic [KEEP_WIDTH-1:0] s_axis_tkeep_1,
  input  logic                  s_axis_tvalid_1,
  output logic                  s_axis_tready_1,
  input  logic                  s_axis_tlast_1,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata_2,
  input  logic [KEEP_WIDTH-1:0] s_axis_tkeep_2,
  input  logic                  s_axis_tvalid_2,
  output logic                  s_axis_tready_2,
  input  logic                  s_axis_tlast_2,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic                  sync_err
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FIFO_DEPTH);

  logic [2:0]             in_valid;
  logic [2:0]             in_last;
  logic [2:0]             in_ready;
  logic [2:0]             not_empty;
  logic [CLASS_WIDTH-1:0] in_label   [3];
  logic [CLASS_WIDTH-1:0] head_label [3];
  logic [2:0]             head_last;
  logic                   pop;

  // Keep and upper tdata bits carry no information for the vote.
  logic unused_inputs;
  assign unused_inputs = ^{s_axis_tkeep_0, s_axis_tkeep_1, s_axis_tkeep_2,
                           s_axis_tdata_0[DATA_WIDTH-1:CLASS_WIDTH],
                           s_axis_tdata_1[DATA_WIDTH-1:CLASS_WIDTH],
                           s_axis_tdata_2[DATA_WIDTH-1:CLASS_WIDTH]};

  assign in_valid    = {s_axis_tvalid_2, s_axis_tvalid_1, s_axis_tvalid_0};
  assign in_last     = {s_axis_tlast_2, s_axis_tlast_1, s_axis_tlast_0};
  assign in_label[0] = s_axis_tdata_0[CLASS_WIDTH-1:0];
  assign in_label[1] = s_axis_tdata_1[CLASS_WIDTH-1:0];
  assign in_label[2] = s_axis_tdata_2[CLASS_WIDTH-1:0];

  assign s_axis_tready_0 = in_ready[0];
  assign s_axis_tready_1 = in_ready[1];
  assign s_axis_tready_2 = in_ready[2];

  // A sample is consumed from all three FIFOs at once when the output
  // register is empty or being drained this cycle.
  assign pop = (&not_empty) && (!m_axis_tvalid || m_axis_tready);

  for (genvar ch = 0; ch < 3; ch++) begin : g_ch
    logic [CLASS_WIDTH:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [CNT_W-1:0]     count;
    logic                 wr;

    // Ready is low during reset so nothing is accepted into a clearing FIFO.
    assign in_ready[ch]   = (count != DEPTH_CNT) && !rst;
    assign wr             = in_valid[ch] && in_ready[ch];
    assign not_empty[ch]  = (count != '0);
    assign head_label[ch] = mem[rd_ptr][CLASS_WIDTH-1:0];
    assign head_last[ch]  = mem[rd_ptr][CLASS_WIDTH];

    // Entry storage; contents are don't-care until the slot is written.
    always_ff @(posedge clk) begin
      if (wr) mem[wr_ptr] <= {in_last[ch], in_label[ch]};
    end

    // Pointers wrap naturally (power-of-two depth); occupancy tracks fill.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (wr)  wr_ptr <= wr_ptr + 1'b1;
        if (pop) rd_ptr <= rd_ptr + 1'b1;
        case ({wr, pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end
  end

  logic [CLASS_WIDTH-1:0] lbl_a, lbl_b, lbl_c, tie_label, vote_label;
  logic [DATA_WIDTH-1:0]  vote_data;

  assign lbl_a     = head_label[0];
  assign lbl_b     = head_label[1];
  assign lbl_c     = head_label[2];
  assign tie_label = head_label[TIE_SEL];

  // Majority vote; a three-way disagreement falls back to the TIE_SEL channel.
  always_comb begin
    vote_label = tie_label;
    if (lbl_a == lbl_b || lbl_a == lbl_c) vote_label = lbl_a;
    else if (lbl_b == lbl_c)              vote_label = lbl_b;
  end

`ifdef ENSEMBLE_AGREE_CNT_EN
  logic [1:0] agree_cnt;

  // Number of classifiers backing the voted label.
  always_comb begin
    agree_cnt = 2'd1;
    if (lbl_a == lbl_b && lbl_b == lbl_c)
      agree_cnt = 2'd3;
    else if (lbl_a == lbl_b || lbl_a == lbl_c || lbl_b == lbl_c)
      agree_cnt = 2'd2;
  end
`endif

  // Assemble the output word: label in the low bits, optional count at [17:16].
  always_comb begin
    vote_data = '0;
    vote_data[CLASS_WIDTH-1:0] = vote_label;
`ifdef ENSEMBLE_AGREE_CNT_EN
    vote_data[17:16] = agree_cnt;
`endif
  end

  assign m_axis_tkeep = '1;

  // Output register: load on pop, clear valid when drained with nothing new.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tlast  <= 1'b0;
    end else if (pop) begin
      m_axis_tvalid <= 1'b1;
      m_axis_tdata  <= vote_data;
      m_axis_tlast  <= head_last[0];
    end else if (m_axis_tready) begin
      m_axis_tvalid <= 1'b0;
    end
  end

  // Sticky flag: channels disagreed on batch boundary for a popped sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_err <= 1'b0;
    end else if (pop && !((&head_last) || !(|head_last))) begin
      sync_err <= 1'b1;
    end
  end

endmodule

// File: doc/ensemble_vote_combiner.md
# ensemble_vote_combiner

- Sits directly downstream of the three-classifier ensemble wrapper (gradient boost, logistic regression, MLP).
- Consumes the three per-sample prediction streams, aligns them despite differing classifier latencies, and majority-votes one class label per sample.
- Emits the vote on a single AXI-Stream master.
- Per-channel FIFOs absorb latency skew; a registered output stage provides one-vote-per-cycle throughput under backpressure.

## Interface
- DATA_WIDTH, 32, tdata width of all streams
- KEEP_WIDTH, 4, tkeep width of all streams
- CLASS_WIDTH, 8, label bits taken from tdata[CLASS_WIDTH-1:0]; upper bits ignored
- FIFO_DEPTH, 4, entries per channel FIFO, power of two, ≥2
- TIE_SEL, 2, channel whose label wins a three-way disagreement (0..2)

- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- s_axis_tdata_0/1/2  in  DATA_WIDTH  classifier predictions
- s_axis_tkeep_0/1/2  in  KEEP_WIDTH  ignored
- s_axis_tvalid_0/1/2  in  1  prediction valid
- s_axis_tready_0/1/2  out  1  channel FIFO not full and rst low
- s_axis_tlast_0/1/2  in  1  end of batch, stored with each entry
- m_axis_tdata  out  DATA_WIDTH  voted label (plus optional agreement count)
- m_axis_tkeep  out  KEEP_WIDTH  constant all ones
- m_axis_tvalid  out  1  vote valid
- m_axis_tready  in  1  downstream accept
- m_axis_tlast  out  1  tlast of channel 0's popped entry
- sync_err  out  1  sticky: popped tlast bits disagreed

## Operation
- Each channel: circular FIFO of FIFO_DEPTH entries of {tlast, label}. Write on tvalid&&tready. Pointers wrap modulo FIFO_DEPTH. Occupancy counter 0..FIFO_DEPTH.
- pop = all three FIFOs non-empty && (!m_axis_tvalid || m_axis_tready). A pop removes exactly one entry from every FIFO in the same cycle.
- Vote on popped labels a (ch0), b (ch1), c (ch2):
  - a==b or a==c → a
  - else b==c → b
  - else → label of channel TIE_SEL
- Agreement count:
  - 3 if a==b==c
  - 2 if exactly two match
  - 1 on tie
- On pop, output register loads the vote, m_axis_tvalid=1.
- If no pop and m_axis_tready=1, m_axis_tvalid clears.
- While m_axis_tvalid=1 and m_axis_tready=0, tdata/tlast hold stable.
- sync_err sets when a pop has tlast bits not all equal. It clears only on reset.
- Same-cycle write and pop on one FIFO: occupancy unchanged. Legal when full (tready low, so no write) and when empty (pop not possible).

## Timing
- Reset values:
  - all FIFOs empty, pointers 0
  - m_axis_tvalid=0, m_axis_tdata=0, m_axis_tlast=0
  - m_axis_tkeep=all ones
  - sync_err=0
  - s_axis_tready_*=0 while rst is high, 1 after release
- Latency: when the last of the three channel words for a sample is accepted at edge t, m_axis_tvalid is high after edge t+1.
- Throughput: one vote per cycle when all channels stream continuously and m_axis_tready=1.
- s_axis_tready_i falls the cycle after the edge that makes FIFO i full. It rises the cycle after a pop frees an entry.
- Reset asserted mid-stream: all buffered entries and any pending output are discarded immediately (asynchronous).

## Configuration
- ENSEMBLE_AGREE_CNT_EN defined:
  - m_axis_tdata[17:16] = agreement count (2'd1..2'd3)
  - m_axis_tdata[CLASS_WIDTH-1:0] = voted label
  - all other bits zero
- Not defined: m_axis_tdata = voted label zero-extended; bits [17:16] always zero; no count logic synthesized.

## Test plan
- All agree: ch0=ch1=ch2=0x05, tready=1 → one beat tdata=0x00000005 (0x00030005 with ENSEMBLE_AGREE_CNT_EN), valid one cycle after the last accept.
- Two-one split: labels 0x03,0x07,0x03 → 0x03 (count 2). Labels 0x09,0x01,0x01 → 0x01 (count 2).
- Three-way tie: labels 0x01,0x02,0x04, TIE_SEL=2 → 0x04 (count 1). Repeat with TIE_SEL=0 → 0x01.
- Skew and backpressure:
  - Stimulus: ch0/ch1 send 4 labels back-to-back; ch2 sends the same 4 labels starting 3 cycles later; m_axis_tready=0 for 10 cycles.
  - Response: 4 votes in order, none lost or duplicated; ch0/ch1 tready low once 4 entries are buffered; tdata held stable while stalled.
- tlast mismatch: ch0 tlast=1 on sample 2, ch1/ch2 tlast=0 → m_axis_tlast=1 on vote 2; sync_err=1 from the next cycle onward until reset.
- Reset mid-stream: assert rst with 2 entries buffered per channel and m_axis_tvalid=1 → tvalid=0 and all FIFOs empty immediately. After release, a fresh sample 0x0A,0x0A,0x0B → 0x0A; no stale data appears.
